// File: rtl/letter_scroller.sv
// letter_scroller
//   Holds a short message of 5-bit letter codes and time-multiplexes it across
//   a common-segment multi-digit display. It can optionally scroll the message
//   left at a fixed rate. Each refresh slot gets one registered letter code and
//   an active-low anode select. A downstream decoder consumes the code
//   combinationally.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   wr_en      write strobe for the message buffer
//   wr_addr    buffer entry to write (entries >= MSG_DEPTH are ignored)
//   wr_data    letter code to store
//   msg_len    active message length (values above MSG_DEPTH saturate)
//   scroll_en  advance the start pointer every SCROLL_DIV cycles
//   code       letter code for the currently selected digit
//   an         one-hot-low digit enable
//   wrap       one-cycle pulse after the start pointer returns to 0
module letter_scroller #(
  parameter int DIGITS      = 4,
  parameter int MSG_DEPTH   = 16,
  parameter int REFRESH_DIV = 50000,
  parameter int SCROLL_DIV  = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [4:0]        wr_data,
  input  logic [4:0]        msg_len,
  input  logic              scroll_en,
  output logic [4:0]        code,
  output logic [DIGITS-1:0] an,
  output logic              wrap
);

  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(SCROLL_DIV);
  localparam logic [4:0] PAD = 5'd31;

  logic [4:0]    mem [MSG_DEPTH];
  logic [AW-1:0] start;
  logic [IW-1:0] idx;
  logic [RW-1:0] ref_cnt;
  logic [SW-1:0] scr_cnt;

  logic [4:0]    len_eff;
  logic [4:0]    start_x;
  logic [4:0]    idx_x;
  logic [4:0]    sum;
  logic [4:0]    rd_sum;
  logic [AW-1:0] rd_addr;
  logic          pad;
  logic [4:0]    code_next;
  logic          ref_tick;
  logic          scr_tick;
  logic          clamp;
  logic          step;
  logic          last;
  logic          wr_ok;

  always_comb begin
    len_eff  = (msg_len > 5'(MSG_DEPTH)) ? 5'(MSG_DEPTH) : msg_len;
    start_x  = 5'(start);
    idx_x    = 5'(idx);
    // With start < L and idx < L the sum is below 2L, so one conditional
    // subtract replaces a full modulo.
    sum      = start_x + idx_x;
    rd_sum   = (sum >= len_eff) ? sum - len_eff : sum;
    rd_addr  = AW'(rd_sum);
    pad      = (idx_x >= len_eff);
    code_next = pad ? PAD : mem[rd_addr];

    ref_tick = (ref_cnt == RW'(REFRESH_DIV - 1));
    scr_tick = scroll_en && (scr_cnt == SW'(SCROLL_DIV - 1));
    // A length drop that strands the start pointer takes priority over a step.
    clamp    = (start_x >= len_eff);
    step     = scr_tick && (len_eff != 5'd0) && !clamp;
    last     = (start_x == len_eff - 5'd1);
    wr_ok    = wr_en && ({1'b0, wr_addr} < 5'(MSG_DEPTH));
  end

  // Message buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MSG_DEPTH; i++) mem[i] <= PAD;
    end else if (wr_ok) begin
      mem[AW'(wr_addr)] <= wr_data;
    end
  end

  // Refresh timing and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else begin
      ref_cnt <= ref_tick ? '0 : ref_cnt + 1'b1;
      if (ref_tick) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Scroll timing and start pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scr_cnt <= '0;
      start   <= '0;
      wrap    <= 1'b0;
    end else begin
      if (scroll_en) scr_cnt <= scr_tick ? '0 : scr_cnt + 1'b1;
      if (clamp)     start <= '0;
      else if (step) start <= last ? '0 : start + 1'b1;
      wrap <= step && last;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code <= PAD;
      an   <= ~DIGITS'(1);
    end else begin
      code <= code_next;
      an   <= ~(DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_letter_scroller.sv
module tb_letter_scroller;

  localparam int DIG  = 4;
  localparam int DEP  = 16;
  localparam int RDIV = 4;
  localparam int SDIV = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic [4:0] msg_len = '0;
  logic       scroll_en = 1'b0;
  logic [4:0] code;
  logic [3:0] an;
  logic       wrap;

  letter_scroller #(
    .DIGITS(DIG), .MSG_DEPTH(DEP), .REFRESH_DIV(RDIV), .SCROLL_DIV(SDIV)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .scroll_en(scroll_en), .code(code), .an(an), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: message contents, start position, and elapsed / enabled
  // cycle counts since reset. The digit slot and scroll instants follow from
  // the counts arithmetically.
  int m_mem [DEP];
  int m_start;
  int m_n;
  int m_en;
  int wrap_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEP; i++) m_mem[i] = 31;
    m_start = 0;
    m_n = 0;
    m_en = 0;
  endtask

  // Called just after a falling edge with inputs already set for the coming edge.
  task automatic step(input bit do_chk);
    int L, idx;
    bit st, code_ok;
    logic [31:0] e_code;
    logic [3:0]  e_an;
    bit e_wrap;
    L   = (int'(msg_len) > DEP) ? DEP : int'(msg_len);
    idx = (m_n / RDIV) % DIG;
    e_an = ~(4'b0001 << idx);
    e_code = (idx >= L) ? 32'd31 : 32'(m_mem[(m_start + idx) % L]);
    // The cycle in which a shortened length strands the start pointer shows a transient.
    code_ok = !(m_start >= L && idx < L);
    st = scroll_en && (m_en % SDIV == SDIV - 1);
    e_wrap = st && L > 0 && m_start == L - 1;
    if (m_start >= L) m_start = 0;
    else if (st && L > 0) m_start = (m_start + 1) % L;
    if (wr_en && int'(wr_addr) < DEP) m_mem[wr_addr] = int'(wr_data);
    m_n++;
    if (scroll_en) m_en++;
    @(posedge clk);
    @(negedge clk);
    if (wrap) wrap_cnt++;
    if (do_chk) begin
      if (code_ok) chk("code", 32'(code), e_code);
      chk("an", 32'(an), 32'(e_an));
      chk("wrap", 32'(wrap), 32'(e_wrap));
    end
  endtask

  task automatic write(input int a, input int d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = 5'(d);
    step(1);
    wr_en = 1'b0;
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_code", 32'(code), 32'd31);
    chk("reset_an", 32'(an), 32'b1110);
    chk("reset_wrap", 32'(wrap), 32'd0);
    rst = 1'b0;

    // Empty message: pad everywhere, anodes rotating every RDIV cycles.
    repeat (3 * DIG * RDIV) step(1);

    // Static four-letter message.
    for (int i = 0; i < 4; i++) write(i, i);
    msg_len = 5'd4;
    repeat (3 * DIG * RDIV + 1) step(1);

    // Six-letter scroll; exactly one wrap over six steps.
    write(4, 4); write(5, 5);
    msg_len = 5'd6;
    scroll_en = 1'b1;
    wrap_cnt = 0;
    repeat (6 * SDIV) step(1);
    chk("wrap_count", 32'(wrap_cnt), 32'd1);
    repeat (SDIV) step(1);

    // Two-letter message with padding, then one scroll step.
    scroll_en = 1'b0;
    write(0, 7); write(1, 8);
    msg_len = 5'd2;
    repeat (2 * DIG * RDIV) step(1);
    scroll_en = 1'b1;
    repeat (2 * SDIV) step(1);

    // Scroll to start 5 of a six-letter message, then shorten it.
    for (int i = 0; i < 6; i++) write(i, i);
    msg_len = 5'd6;
    guard = 0;
    while (m_start != 5 && guard < 400) begin step(1); guard++; end
    chk("reach_start5", 32'(guard < 400), 32'd1);
    msg_len = 5'd3;
    scroll_en = 1'b0;
    wrap_cnt = 0;
    repeat (2 * DIG * RDIV) step(1);
    chk("no_wrap_on_clamp", 32'(wrap_cnt), 32'd0);
    guard = 0;
    while (((m_n / RDIV) % DIG) != 1 && guard < 64) begin step(1); guard++; end
    write(1, 12);
    repeat (2 * DIG * RDIV) step(1);

    // Random traffic.
    scroll_en = 1'b1;
    for (int k = 0; k < 800; k++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 4'($urandom);
      wr_data = 5'($urandom);
      if ($urandom_range(0, 39) == 0) msg_len = 5'($urandom_range(0, 20));
      if ($urandom_range(0, 49) == 0) scroll_en = ~scroll_en;
      step(1);
    end
    wr_en = 1'b0;

    // Asynchronous reset in the middle of scrolling.
    msg_len = 5'd16;
    scroll_en = 1'b1;
    repeat (37) step(1);
    #2 rst = 1'b1;
    #1;
    chk("async_code", 32'(code), 32'd31);
    chk("async_an", 32'(an), 32'b1110);
    chk("async_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (DEP * SDIV + 2 * RDIV) step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
